// File: rtl/dff_reset_bit.sv
// rtl/dff_reset_bit.sv - single-bit D flop with synchronous active-low reset and complemented output
module dff_reset_bit (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= rst_val;
        end else begin
            q <= d;
        end
    end

    // qn comes from the same flop so it can never be a cycle skewed from q
    assign qn = ~q;

endmodule

// File: rtl/dff_reset.sv
// rtl/dff_reset.sv - WIDTH-bit D register bank with synchronous active-low reset and true/complement outputs
module dff_reset #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_reset_bit u_bit (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VALUE[i]),
            .d       (d[i]),
            .q       (q[i]),
            .qn      (qn[i])
        );
    end

endmodule

// File: tb/tb_dff_reset.sv
// tb/tb_dff_reset.sv - scoreboard bench for dff_reset at WIDTH 8, 1 and 16
module tb_dff_reset;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  d8;
    logic [7:0]  q8, qn8;
    logic [0:0]  d1;
    logic [0:0]  q1, qn1;
    logic [15:0] d16;
    logic [15:0] q16, qn16;

    always #5 clk = ~clk;

    dff_reset u_dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8),
        .qn    (qn8)
    );

    dff_reset #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1),
        .qn    (qn1)
    );

    dff_reset #(.WIDTH(16), .RESET_VALUE(16'hA5A5)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .d     (d16),
        .q     (q16),
        .qn    (qn16)
    );

    typedef struct {
        logic [7:0]  e8;
        logic [0:0]  e1;
        logic [15:0] e16;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs mid-cycle, then record what the register must hold after the coming edge.
    task automatic cycle(input logic r, input logic [7:0] a, input logic [0:0] b, input logic [15:0] c);
        exp_t e;
        reset = r;
        d8    = a;
        d1    = b;
        d16   = c;
        @(posedge clk);
        e.e8  = r ? a : 8'h00;
        e.e1  = r ? b : 1'b0;
        e.e16 = r ? c : 16'hA5A5;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t cur;
        bit   have = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                cur  = sb.pop_front();
                have = 1;
                chk("q8",   {8'h00, q8},   {8'h00, cur.e8});
                chk("qn8",  {8'h00, qn8},  {8'h00, ~cur.e8});
                chk("q1",   {15'h0, q1},   {15'h0, cur.e1});
                chk("qn1",  {15'h0, qn1},  {15'h0, ~cur.e1});
                chk("q16",  q16,           cur.e16);
                chk("qn16", qn16,          ~cur.e16);
            end
            if (have) begin
                // inputs have changed by now; outputs must still hold until the next edge
                #3;
                chk("hold_q8",  {8'h00, q8},  {8'h00, cur.e8});
                chk("hold_q1",  {15'h0, q1},  {15'h0, cur.e1});
                chk("hold_q16", q16,          cur.e16);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin : driver
        reset = 1'b0;
        d8    = 8'h3C;
        d1    = 1'b1;
        d16   = 16'h1234;
        @(negedge clk);
        #1;
        cycle(1'b0, 8'h3C, 1'b1, 16'h1234);
        cycle(1'b0, 8'hC3, 1'b1, 16'hFFFF);
        cycle(1'b1, 8'hAA, 1'b1, 16'hAAAA);
        cycle(1'b1, 8'hF0, 1'b0, 16'h0F0F);
        cycle(1'b0, 8'hF0, 1'b1, 16'hF0F0);
        cycle(1'b0, 8'h0F, 1'b1, 16'h5A5A);
        cycle(1'b0, 8'h0F, 1'b1, 16'h0000);
        cycle(1'b1, 8'h0F, 1'b0, 16'h0000);
        cycle(1'b1, 8'hFF, 1'b1, 16'hFFFF);
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 9) != 0),
                  8'($urandom), 1'($urandom), 16'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 16'(sb.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
